// File: rtl/fir_axil_pkg.sv
// Shared types and constants for the FIR AXI-Lite configuration master.
// State encoding, FIR register map and default bus widths.
package fir_axil_pkg;

    localparam int AXIL_ADDR_W  = 12;
    localparam int AXIL_DATA_W  = 32;
    localparam int AXIL_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD_AR = 3'd2,
        ST_RD_R  = 3'd3,
        ST_RSP   = 3'd4
    } axil_state_t;

    localparam logic [11:0] FIR_ADDR_AP_CTRL     = 12'h000;
    localparam logic [11:0] FIR_ADDR_DATA_LENGTH = 12'h010;
    localparam logic [11:0] FIR_ADDR_TAP_BASE    = 12'h020;

    function automatic logic axil_bus_active(input axil_state_t s);
        return (s == ST_WR) || (s == ST_RD_AR) || (s == ST_RD_R);
    endfunction

endpackage

// File: rtl/axil_cfg_wdog.sv
// Transaction watchdog: counts cycles spent waiting on the bus and flags
// the cycle in which the count reaches pTIMEOUT.
module axil_cfg_wdog #(
    parameter int pTIMEOUT = 255
) (
    input  logic axis_clk,
    input  logic axis_rst,
    input  logic active,
    output logic expired
);

    localparam int CW = $clog2(pTIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(pTIMEOUT);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(pTIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is zero outside the bus-wait states and saturates at the limit.
    always_comb begin
        cnt_d = '0;
        if (active) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = active && (cnt_q >= CNT_LIMIT);

endmodule

// File: rtl/axilite_cfg_master.sv
// AXI-Lite initiator turning a command/response handshake into AW/W/AR/R traffic
// (no B channel). Optional watchdog enabled by AXILITE_CFG_MASTER_TIMEOUT_EN.
//
//   state    | meaning
//   IDLE     | waiting for a command, cmd_ready high
//   WR       | AW and W outstanding, each drops independently on handshake
//   RD_AR    | read address outstanding
//   RD_R     | rready high, waiting for read data
//   RSP      | response held until rsp_ready
module axilite_cfg_master
    import fir_axil_pkg::*;
#(
    parameter int pADDR_WIDTH = AXIL_ADDR_W,
    parameter int pDATA_WIDTH = AXIL_DATA_W,
    parameter int pTIMEOUT    = AXIL_TIMEOUT
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [pDATA_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [pDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [pDATA_WIDTH-1:0] wdata,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   busy
);

    axil_state_t            state_q, state_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [pDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [pADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                   tmo_expired;

`ifdef AXILITE_CFG_MASTER_TIMEOUT_EN
    axil_cfg_wdog #(
        .pTIMEOUT (pTIMEOUT)
    ) u_wdog (
        .axis_clk (axis_clk),
        .axis_rst (axis_rst),
        .active   (axil_bus_active(state_q)),
        .expired  (tmo_expired)
    );
`else
    // No watchdog: the bus wait is unbounded.
    assign tmo_expired = (pTIMEOUT < 0);
`endif

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    awaddr_d = cmd_addr;
                    araddr_d = cmd_addr;
                    wdata_d  = cmd_wdata;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_AR;
                    end
                end
            end
            ST_WR: begin
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Completion has priority over a coincident timeout.
                if (aw_done_d && w_done_d) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RSP;
                end else if (tmo_expired) begin
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RD_AR: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_R;
                end else if (tmo_expired) begin
                    arvalid_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RD_R: begin
                if (rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rdata;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RSP;
                end else if (tmo_expired) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign awaddr    = awaddr_q;
    assign araddr    = araddr_q;
    assign wdata     = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_axilite_cfg_master.sv
// Bench for axilite_cfg_master: directed vector table, reset and timeout
// sequences, then random commands against a memory-backed slave and reference.
module tb_axilite_cfg_master;
    import fir_axil_pkg::*;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          axis_clk, axis_rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          awvalid, awready, wvalid, wready, arvalid, arready;
    logic          rvalid, rready, busy;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;

    axilite_cfg_master #(
        .pADDR_WIDTH (AW),
        .pDATA_WIDTH (DW),
        .pTIMEOUT    (TMO)
    ) dut (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .busy      (busy)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt_data(input logic [11:0] a);
        return 32'hDEAD_0000 | {20'h0, a};
    endfunction

    // Slave side: per-channel ready latencies and a memory written by the bus.
    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    int            aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
    logic [31:0]   slv_mem [logic [11:0]];
    wr_t           wr_log [$];

    initial begin
        int          aw_cnt, w_cnt, ar_cnt, r_wait;
        bit          aw_hs_p, w_hs_p, ar_hs_p, r_hs_p, aw_got, w_got, r_pend;
        logic [11:0] aw_a_p, ar_a_p, aw_a;
        logic [31:0] w_d_p, w_d, r_dat;
        awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_wait = 0;
        aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0; r_hs_p = 0;
        aw_got = 0; w_got = 0; r_pend = 0;
        aw_a_p = '0; ar_a_p = '0; aw_a = '0; w_d_p = '0; w_d = '0; r_dat = '0;
        forever begin
            @(negedge axis_clk);
            if (axis_rst) begin
                awready = 0; wready = 0; arready = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0; r_hs_p = 0;
                aw_got = 0; w_got = 0; r_pend = 0;
            end else begin
                if (aw_hs_p) begin
                    aw_got = 1; aw_a = aw_a_p;
                    check("awvalid_drop", 32'(awvalid), 32'd0);
                end
                if (w_hs_p) begin
                    w_got = 1; w_d = w_d_p;
                    check("wvalid_drop", 32'(wvalid), 32'd0);
                end
                if (aw_got && w_got) begin
                    slv_mem[aw_a] = w_d;
                    wr_log.push_back('{a: aw_a, d: w_d});
                    aw_got = 0; w_got = 0;
                end
                if (ar_hs_p) begin
                    check("rready_after_ar", 32'(rready), 32'd1);
                    r_pend = 1; r_wait = r_lat;
                    r_dat = slv_mem.exists(ar_a_p) ? slv_mem[ar_a_p] : dflt_data(ar_a_p);
                end
                if (r_hs_p) begin
                    rvalid = 0;
                    check("rready_drop", 32'(rready), 32'd0);
                end
                awready = awvalid && (aw_cnt >= aw_lat);
                aw_cnt  = awvalid ? aw_cnt + 1 : 0;
                wready  = wvalid && (w_cnt >= w_lat);
                w_cnt   = wvalid ? w_cnt + 1 : 0;
                arready = arvalid && (ar_cnt >= ar_lat);
                ar_cnt  = arvalid ? ar_cnt + 1 : 0;
                if (r_pend && !rvalid) begin
                    if (r_wait == 0) begin
                        rvalid = 1; rdata = r_dat; r_pend = 0;
                    end else begin
                        r_wait--;
                    end
                end
                aw_hs_p = awvalid && awready; aw_a_p = awaddr;
                w_hs_p  = wvalid && wready;   w_d_p  = wdata;
                ar_hs_p = arvalid && arready; ar_a_p = araddr;
                r_hs_p  = rvalid && rready;
            end
        end
    end

    // Issue one command at a negedge; lat = cycles from accept edge to rsp_valid.
    task automatic run_cmd(input bit wr, input logic [11:0] a, input logic [31:0] d,
                           input int bp, output logic [31:0] rd, output logic er,
                           output int lat);
        int t;
        rd = '0; er = 1'b0; lat = -1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge axis_clk); t++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 0;
            return;
        end
        @(negedge axis_clk);
        cmd_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge axis_clk); lat++;
        end
        if (!rsp_valid) begin
            check("rsp_wait_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        rd = rsp_rdata; er = rsp_err;
        check("rsp_bus_quiet", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
        for (int i = 0; i < bp; i++) begin
            cmd_valid = 1; cmd_write = 1; cmd_addr = 12'hFFC; cmd_wdata = '1;
            @(negedge axis_clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, rd);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_no_new_aw", 32'(awvalid), 32'd0);
        end
        cmd_valid = 0;
        rsp_ready = 1;
        @(negedge axis_clk);
        rsp_ready = 0;
        check("idle_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    logic [31:0] ref_mem [logic [11:0]];

    task automatic check_wr_log(input string name, input logic [11:0] a, input logic [31:0] d);
        wr_t e;
        if (wr_log.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got no bus write, expected addr 0x%0h data 0x%0h", name, a, d);
        end else begin
            e = wr_log.pop_front();
            check({name, "_addr"}, {20'd0, e.a}, {20'd0, a});
            check({name, "_data"}, e.d, d);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        int          aw_l, w_l, ar_l, r_l, bp;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t        vecs [9];
        logic [31:0] rd, exp_rd;
        logic        er;
        int          lat, exp_lat;
        bit          wr;
        logic [11:0] a;
        logic [31:0] d;
        int          bp;

        vecs[0] = '{1'b1, FIR_ADDR_TAP_BASE,    32'h0000_0005, 0, 0, 0, 0, 0, 32'h0,         2};
        vecs[1] = '{1'b1, 12'h024,              32'h1234_5678, 1, 4, 0, 0, 0, 32'h0,         6};
        vecs[2] = '{1'b1, FIR_ADDR_DATA_LENGTH, 32'h0000_0258, 0, 0, 0, 0, 0, 32'h0,         2};
        vecs[3] = '{1'b0, FIR_ADDR_DATA_LENGTH, 32'h0,         0, 0, 0, 3, 0, 32'h0000_0258, 6};
        vecs[4] = '{1'b0, FIR_ADDR_TAP_BASE,    32'h0,         0, 0, 0, 0, 5, 32'h0000_0005, 3};
        vecs[5] = '{1'b0, FIR_ADDR_AP_CTRL,     32'h0,         0, 0, 0, 0, 0, 32'hDEAD_0000, 3};
        vecs[6] = '{1'b1, FIR_ADDR_AP_CTRL,     32'h0000_0001, 3, 0, 0, 0, 0, 32'h0,         5};
        vecs[7] = '{1'b0, 12'h024,              32'h0,         0, 0, 2, 1, 0, 32'h1234_5678, 6};
        vecs[8] = '{1'b1, 12'h030,              32'h0000_A5A5, 2, 2, 0, 0, 1, 32'h0,         4};

        axis_rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
        repeat (3) @(negedge axis_clk);
        check("rst_outputs", {22'd0, awvalid, wvalid, arvalid, rready, rsp_valid, rsp_err,
                              busy, 1'b0, 1'b0, cmd_ready}, 32'd1);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_awaddr", {20'd0, awaddr}, 32'd0);
        check("rst_araddr", {20'd0, araddr}, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        axis_rst = 0;
        @(negedge axis_clk);

        for (int i = 0; i < 9; i++) begin
            aw_lat = vecs[i].aw_l; w_lat = vecs[i].w_l; ar_lat = vecs[i].ar_l; r_lat = vecs[i].r_l;
            run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].bp, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(er), 32'd0);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].wr) begin
                check_wr_log($sformatf("vec%0d_bus", i), vecs[i].addr, vecs[i].data);
                ref_mem[vecs[i].addr] = vecs[i].data;
            end
        end

        // Asynchronous reset while a write is outstanding.
        aw_lat = 20; w_lat = 20;
        cmd_valid = 1; cmd_write = 1; cmd_addr = FIR_ADDR_TAP_BASE; cmd_wdata = 32'h0000_0BAD;
        @(negedge axis_clk);
        cmd_valid = 0;
        check("pre_rst_wr_valids", {30'd0, awvalid, wvalid}, 32'd3);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 axis_rst = 1;
        #1;
        check("async_rst_valids", {30'd0, awvalid, wvalid}, 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge axis_clk);
        @(negedge axis_clk);
        axis_rst = 0;
        aw_lat = 0; w_lat = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge axis_clk);
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("post_rst_no_write", 32'(wr_log.size()), 32'd0);
        run_cmd(1'b0, FIR_ADDR_TAP_BASE, 32'h0, 0, rd, er, lat);
        check("post_rst_read", rd, ref_mem[FIR_ADDR_TAP_BASE]);
        check("post_rst_read_lat", 32'(lat), 32'd3);

`ifdef AXILITE_CFG_MASTER_TIMEOUT_EN
        ar_lat = 1000;
        run_cmd(1'b0, FIR_ADDR_DATA_LENGTH, 32'h0, 0, rd, er, lat);
        check("tmo_rdata", rd, 32'd0);
        check("tmo_err", 32'(er), 32'd1);
        check("tmo_latency", 32'(lat), 32'(TMO + 1));
        ar_lat = 0;
`endif

        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 12'($urandom_range(0, 15) * 4);
            d  = $urandom;
            bp = $urandom_range(0, 2);
            aw_lat = $urandom_range(0, 2); w_lat = $urandom_range(0, 2);
            ar_lat = $urandom_range(0, 2); r_lat = $urandom_range(0, 2);
            if (wr) begin
                exp_rd  = 32'd0;
                exp_lat = 2 + ((aw_lat > w_lat) ? aw_lat : w_lat);
            end else begin
                exp_rd  = ref_mem.exists(a) ? ref_mem[a] : dflt_data(a);
                exp_lat = 3 + ar_lat + r_lat;
            end
            run_cmd(wr, a, d, bp, rd, er, lat);
            check($sformatf("rnd%0d_rdata", n), rd, exp_rd);
            check($sformatf("rnd%0d_err", n), 32'(er), 32'd0);
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(exp_lat));
            if (wr) begin
                check_wr_log($sformatf("rnd%0d_bus", n), a, d);
                ref_mem[a] = d;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no completion, expected finish before 200000");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/axilite_cfg_master.md
Name: axilite_cfg_master

Overview:
- AXI-Lite initiator: the requester side of the FIR's AXI-Lite register/tap port.
- Turns a simple command/response interface into AW/W/AR/R channel traffic.
- Used by the test harness and the future controller to load taps, start the FIR and poll status.
- Matches the FIR's AXI-Lite subset: no B channel. A write completes when both the AW and W handshakes are done.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width.
- pDATA_WIDTH, 32, AXI-Lite data width.
- pTIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- axis_clk  in  1  sole clock, rising edge.
- axis_rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  pADDR_WIDTH  target address.
- cmd_wdata  in  pDATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  pDATA_WIDTH  read data (0 for writes).
- rsp_err  out  1  transaction aborted by timeout.
- awvalid  out  1  write-address valid.
- awready  in  1  write-address ready.
- awaddr  out  pADDR_WIDTH  write address.
- wvalid  out  1  write-data valid.
- wready  in  1  write-data ready.
- wdata  out  pDATA_WIDTH  write data.
- arvalid  out  1  read-address valid.
- arready  in  1  read-address ready.
- araddr  out  pADDR_WIDTH  read address.
- rvalid  in  1  read-data valid.
- rready  out  1  read-data ready.
- rdata  in  pDATA_WIDTH  read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: axis_rst high asynchronously forces state to IDLE and clears every output register to 0. This covers awvalid, wvalid, arvalid, rready, rsp_valid, rsp_rdata, rsp_err, awaddr, wdata, araddr, the aw_done/w_done flags and the timer.
- Reset mid-transaction abandons the transaction silently; no response is produced.
- States: IDLE, WR, RD_AR, RD_R, RSP. Binary encoded, registered.
- cmd_ready = (state == IDLE), combinational from state.
- IDLE:
  - On cmd_valid, register cmd_addr/cmd_wdata.
  - Write: go to WR with awvalid = wvalid = 1 the next cycle.
  - Read: go to RD_AR with arvalid = 1 the next cycle.
- WR:
  - awvalid deasserts the cycle after awvalid & awready, and aw_done is set. wvalid/w_done behave the same way.
  - Channels are independent: either may complete first, or both in the same cycle.
  - When both are done (including in the same cycle), go to RSP with rsp_rdata = 0.
- RD_AR: on arvalid & arready, drop arvalid, set rready = 1, go to RD_R.
- RD_R:
  - rvalid is sampled only here; the slave must hold rvalid/rdata until rready.
  - On rvalid & rready, capture rdata into rsp_rdata, drop rready, go to RSP.
- RSP: rsp_valid = 1 with stable rsp_rdata/rsp_err until rsp_valid & rsp_ready, then IDLE. cmd_ready stays 0 while in RSP.
- Latency, with an always-ready slave and command accepted at edge N:
  - Write: awvalid/wvalid high in cycle N+1; rsp_valid high in cycle N+2.
  - Read: arvalid high in N+1, rready high in N+2, rsp_valid high in N+3.
- Back-to-back: the earliest next command accept is the cycle in which rsp_ready is taken (state returns to IDLE at that edge). There is no overlap of transactions.
- Addresses and data pass through unchanged; no alignment or width conversion is applied.

Optional Feature:
- Macro: AXILITE_CFG_MASTER_TIMEOUT_EN.
- Defined:
  - A cycle counter of clog2(pTIMEOUT+1) bits clears on leaving IDLE and increments each cycle in WR/RD_AR/RD_R.
  - When it reaches pTIMEOUT, all valids and rready drop and the state goes to RSP with rsp_err = 1 and rsp_rdata = 0.
  - A handshake in the same cycle as the timeout wins: normal completion, rsp_err = 0.
- Undefined: no counter; rsp_err is tied to 0; the block waits indefinitely.

Decomposition:
- Package fir_axil_pkg:
  - state encoding constants (IDLE=0, WR=1, RD_AR=2, RD_R=3, RSP=4);
  - FIR register address constants (ap_ctrl 0x00, data_length 0x10, tap base 0x20);
  - default width localparams.
- One sub-module, axil_cfg_wdog, containing only the timeout counter. It is instantiated only under the macro.

Test Plan:
1. Write, always-ready slave: cmd write addr 0x020 data 0x0000_0005 -> awvalid/wvalid high one cycle with awaddr=0x020, wdata=5; rsp_valid two cycles after accept; rsp_rdata=0.
2. Skewed write: awready at +1 cycle, wready at +4 cycles -> awvalid drops after its handshake, wvalid held until +4; rsp_valid the cycle after the W handshake.
3. Read: cmd read 0x010, slave rvalid 3 cycles after AR with rdata 0x0000_0258 -> rsp_rdata=0x258, rsp_err=0; rready high only in RD_R.
4. Response backpressure: rsp_ready low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0; a new cmd_valid is ignored until the response is taken.
5. Async reset while in WR (awvalid high) -> awvalid/wvalid 0 immediately, busy=0, no response; a following read works normally.
6. With the macro, pTIMEOUT=8, slave never asserts arready -> arvalid drops after 8 cycles in RD_AR; rsp_valid=1, rsp_err=1, rsp_rdata=0.
